// File: rtl/instr_fetch_queue_pkg.sv
// Shared types and constants for the instruction fetch queue.
// The fetch FSM states and the PC increment live here so that every file agrees on them.
package instr_fetch_queue_pkg;

    typedef enum logic [1:0] {
        FS_REQ     = 2'd0,
        FS_WAIT    = 2'd1,
        FS_DISCARD = 2'd2
    } fetch_state_t;

    localparam int unsigned PC_INCR = 4;

endpackage

// File: rtl/instr_fetch_queue_fifo.sv
// Synchronous FIFO holding fetched {pc, instr} pairs.
// Flush empties the FIFO and takes priority over a push in the same cycle.
module fetch_fifo #(
    parameter int WIDTH = 64,
    parameter int DEPTH = 4
) (
    input  logic                     clk,
    input  logic                     reset,
    input  logic                     push,
    input  logic [WIDTH-1:0]         push_data,
    input  logic                     pop,
    input  logic                     flush,
    output logic [WIDTH-1:0]         head_data,
    output logic [$clog2(DEPTH):0]   count
);

    localparam int PTR_W = $clog2(DEPTH);
    localparam logic [PTR_W:0] FULL = (PTR_W + 1)'(DEPTH);

    logic [WIDTH-1:0] mem [DEPTH];
    logic [PTR_W-1:0] wr_ptr;
    logic [PTR_W-1:0] rd_ptr;
    logic             do_push;
    logic             do_pop;

    assign do_push = push && (count < FULL);
    assign do_pop  = pop && (count != '0);

    always_ff @(posedge clk) begin
        if (!reset) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else if (flush) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (do_push) wr_ptr <= wr_ptr + 1'b1;
            if (do_pop)  rd_ptr <= rd_ptr + 1'b1;
            case ({do_push, do_pop})
                2'b10:   count <= count + 1'b1;
                2'b01:   count <= count - 1'b1;
                default: count <= count;
            endcase
        end
    end

    // Storage needs no reset: entries are only visible once count says they are valid.
    always_ff @(posedge clk) begin
        if (reset && !flush && do_push) mem[wr_ptr] <= push_data;
    end

    assign head_data = (count != '0) ? mem[rd_ptr] : '0;

endmodule

// File: rtl/instr_fetch_queue.sv
// Instruction fetch stage: owns the fetch PC, issues one word read at a time and
// buffers returned words with their PC for the decode path; restarts on redirect.
module instr_fetch_queue
    import instr_fetch_queue_pkg::*;
#(
    parameter int                ADDR_W   = 32,
    parameter int                DATA_W   = 32,
    parameter int                DEPTH    = 4,
    parameter logic [ADDR_W-1:0] RESET_PC = '0
) (
    input  logic              clk,
    input  logic              reset,
    output logic              mem_req_valid,
    input  logic              mem_req_ready,
    output logic [ADDR_W-1:0] mem_req_addr,
    input  logic              mem_rsp_valid,
    input  logic [DATA_W-1:0] mem_rsp_data,
    input  logic              redirect_valid,
    input  logic [ADDR_W-1:0] redirect_pc,
    output logic              out_valid,
    input  logic              out_ready,
    output logic [DATA_W-1:0] out_instr,
    output logic [ADDR_W-1:0] out_pc
);

    localparam int CNT_W = $clog2(DEPTH) + 1;
    localparam logic [CNT_W-1:0] FULL = CNT_W'(DEPTH);

    fetch_state_t               state;
    logic [ADDR_W-1:0]          fetch_pc;
    logic [ADDR_W-1:0]          req_pc;
    logic [CNT_W-1:0]           count;
    logic [ADDR_W+DATA_W-1:0]   head;
    logic                       req_hs;
    logic                       push;
    logic                       pop;

    // Issue only with a free slot, so a returning word can always be stored.
    assign mem_req_valid = reset && (state == FS_REQ) && (count < FULL);
    assign mem_req_addr  = fetch_pc;
    assign req_hs        = mem_req_valid && mem_req_ready;

    assign push      = (state == FS_WAIT) && mem_rsp_valid && !redirect_valid;
    assign out_valid = (count != '0);
    assign pop       = out_valid && out_ready;
    assign {out_pc, out_instr} = head;

    always_ff @(posedge clk) begin
        if (!reset) begin
            fetch_pc <= RESET_PC;
            req_pc   <= '0;
            // A request left in flight still answers later; swallow that answer once.
            if ((state == FS_WAIT || state == FS_DISCARD) && !mem_rsp_valid)
                state <= FS_DISCARD;
            else
                state <= FS_REQ;
        end else if (redirect_valid) begin
            fetch_pc <= redirect_pc;
            if (mem_rsp_valid && state != FS_REQ)
                state <= FS_REQ;
            else if (state == FS_WAIT || state == FS_DISCARD || req_hs)
                state <= FS_DISCARD;
            else
                state <= FS_REQ;
        end else begin
            case (state)
                FS_REQ: begin
                    if (req_hs) begin
                        fetch_pc <= fetch_pc + ADDR_W'(PC_INCR);
                        req_pc   <= fetch_pc;
                        state    <= FS_WAIT;
                    end
                end
                FS_WAIT: begin
                    if (mem_rsp_valid) state <= FS_REQ;
                end
                FS_DISCARD: begin
                    if (mem_rsp_valid) state <= FS_REQ;
                end
                default: state <= FS_REQ;
            endcase
        end
    end

    fetch_fifo #(
        .WIDTH (ADDR_W + DATA_W),
        .DEPTH (DEPTH)
    ) u_fifo (
        .clk       (clk),
        .reset     (reset),
        .push      (push),
        .push_data ({req_pc, mem_rsp_data}),
        .pop       (pop),
        .flush     (redirect_valid),
        .head_data (head),
        .count     (count)
    );

endmodule

// File: tb/tb_instr_fetch_queue.sv
// Directed bench for instr_fetch_queue with a latency-configurable memory model
// and a scoreboard of expected {pc, word} pairs built from accepted requests.
module tb_instr_fetch_queue;

    logic        clk = 1'b0;
    logic        reset = 1'b0;
    logic        mem_req_valid;
    logic        mem_req_ready = 1'b0;
    logic [31:0] mem_req_addr;
    logic        mem_rsp_valid = 1'b0;
    logic [31:0] mem_rsp_data = 32'h0;
    logic        redirect_valid = 1'b0;
    logic [31:0] redirect_pc = 32'h0;
    logic        out_valid;
    logic        out_ready = 1'b0;
    logic [31:0] out_instr;
    logic [31:0] out_pc;

    instr_fetch_queue #(
        .ADDR_W   (32),
        .DATA_W   (32),
        .DEPTH    (4),
        .RESET_PC (32'h0)
    ) dut (
        .clk            (clk),
        .reset          (reset),
        .mem_req_valid  (mem_req_valid),
        .mem_req_ready  (mem_req_ready),
        .mem_req_addr   (mem_req_addr),
        .mem_rsp_valid  (mem_rsp_valid),
        .mem_rsp_data   (mem_rsp_data),
        .redirect_valid (redirect_valid),
        .redirect_pc    (redirect_pc),
        .out_valid      (out_valid),
        .out_ready      (out_ready),
        .out_instr      (out_instr),
        .out_pc         (out_pc)
    );

    always #5 clk = ~clk;

    int          checks = 0;
    int          errors = 0;
    logic [31:0] exp_q[$];
    logic [31:0] pop_log[$];
    logic [31:0] model_pc = 32'h0;
    bit          pend = 1'b0;
    logic [31:0] pend_addr = 32'h0;
    int          pend_cnt = 0;
    int          lat = 1;
    bit          mem_rdy = 1'b1;
    int          hs_seen = 0;

    function automatic logic [31:0] word_of(logic [31:0] a);
        return (a * 32'h9E37_79B1) ^ 32'h5A5A_0F0F;
    endfunction

    task automatic chk(string tag, logic [31:0] obs, logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    // One clock: drive memory response, check outputs, update the model, advance.
    task automatic cycle();
        bit          hs;
        bit          popped;
        bit          rsp;
        logic [31:0] hs_addr;
        logic [31:0] e;
        rsp = pend && (pend_cnt == 0);
        mem_rsp_valid = rsp;
        mem_rsp_data  = rsp ? word_of(pend_addr) : $urandom;
        mem_req_ready = mem_rdy;
        #1;
        hs      = mem_req_valid && mem_req_ready;
        hs_addr = mem_req_addr;
        popped  = out_valid && out_ready;
        if (!reset) chk("req_valid_in_reset", {31'b0, mem_req_valid}, 32'h0);
        if (popped) begin
            chk("pop_has_expected", {31'b0, exp_q.size() != 0}, 32'h1);
            if (exp_q.size() != 0) begin
                e = exp_q.pop_front();
                chk("out_pc", out_pc, e);
                chk("out_instr", out_instr, word_of(e));
            end
            pop_log.push_back(out_pc);
        end
        if (!reset || redirect_valid) begin
            exp_q.delete();
            model_pc = !reset ? 32'h0 : redirect_pc;
        end else if (hs) begin
            chk("req_addr", hs_addr, model_pc);
            exp_q.push_back(model_pc);
            model_pc = model_pc + 32'd4;
        end
        @(posedge clk);
        if (rsp) pend = 1'b0;
        else if (pend && pend_cnt > 0) pend_cnt--;
        if (hs) begin
            pend      = 1'b1;
            pend_addr = hs_addr;
            pend_cnt  = lat - 1;
            hs_seen++;
        end
        @(negedge clk);
    endtask

    initial begin
        int  h0;
        bit  found;
        @(negedge clk);

        // 1: reset, then straight-line fetch with 1-cycle memory
        reset = 1'b0; out_ready = 1'b1; mem_rdy = 1'b1; lat = 1;
        cycle();
        cycle();
        chk("rst_out_valid", {31'b0, out_valid}, 32'h0);
        chk("rst_out_pc", out_pc, 32'h0);
        chk("rst_out_instr", out_instr, 32'h0);
        chk("rst_req_valid", {31'b0, mem_req_valid}, 32'h0);
        reset = 1'b1;
        pop_log.delete();
        repeat (8) cycle();
        chk("t1_pop_count", {31'b0, pop_log.size() >= 3}, 32'h1);
        chk("t1_pc0", pop_log[0], 32'h0);
        chk("t1_pc1", pop_log[1], 32'h4);
        chk("t1_pc2", pop_log[2], 32'h8);

        // 2: back-pressure fills the FIFO, fetch stalls, then resumes
        out_ready = 1'b0;
        repeat (12) cycle();
        chk("t2_full_valid", {31'b0, out_valid}, 32'h1);
        chk("t2_no_req", {31'b0, mem_req_valid}, 32'h0);
        chk("t2_buffered", exp_q.size(), 32'd4);
        chk("t2_head_pc", out_pc, exp_q[0]);
        cycle();
        chk("t2_still_no_req", {31'b0, mem_req_valid}, 32'h0);
        h0 = hs_seen;
        out_ready = 1'b1;
        pop_log.delete();
        repeat (12) cycle();
        chk("t2_drained", {31'b0, pop_log.size() >= 4}, 32'h1);
        chk("t2_fetch_resumed", {31'b0, hs_seen > h0}, 32'h1);

        // 3: redirect while waiting on a slow memory
        lat = 3;
        h0 = hs_seen;
        for (int i = 0; i < 20 && hs_seen == h0; i++) cycle();
        chk("t3_hs_seen", {31'b0, hs_seen != h0}, 32'h1);
        redirect_valid = 1'b1; redirect_pc = 32'h40;
        cycle();
        redirect_valid = 1'b0;
        chk("t3_flushed", {31'b0, out_valid}, 32'h0);
        pop_log.delete();
        repeat (14) cycle();
        chk("t3_first_pc", pop_log[0], 32'h40);

        // 4: redirect coinciding with a push and a pop
        lat = 1;
        out_ready = 1'b0;
        repeat (6) cycle();
        out_ready = 1'b1;
        found = 1'b0;
        for (int i = 0; i < 20 && !found; i++) begin
            if (pend && pend_cnt == 0 && out_valid) found = 1'b1;
            else cycle();
        end
        chk("t4_found_push_pop", {31'b0, found}, 32'h1);
        redirect_valid = 1'b1; redirect_pc = 32'h100;
        cycle();
        redirect_valid = 1'b0;
        chk("t4_out_valid", {31'b0, out_valid}, 32'h0);
        chk("t4_req_state", {31'b0, mem_req_valid}, 32'h1);
        chk("t4_req_addr", mem_req_addr, 32'h100);
        pop_log.delete();
        repeat (6) cycle();
        chk("t4_first_pc", pop_log[0], 32'h100);

        // 5: reset while a slow request is in flight
        lat = 3;
        h0 = hs_seen;
        for (int i = 0; i < 20 && hs_seen == h0; i++) cycle();
        chk("t5_hs_seen", {31'b0, hs_seen != h0}, 32'h1);
        reset = 1'b0;
        cycle();
        reset = 1'b1;
        chk("t5_out_valid", {31'b0, out_valid}, 32'h0);
        chk("t5_out_pc", out_pc, 32'h0);
        pop_log.delete();
        repeat (16) cycle();
        chk("t5_first_pc", pop_log[0], 32'h0);

        // 6: PC wraps past the top of the address space
        lat = 1;
        redirect_valid = 1'b1; redirect_pc = 32'hFFFF_FFFC;
        cycle();
        redirect_valid = 1'b0;
        pop_log.delete();
        repeat (12) cycle();
        chk("t6_pc_top", pop_log[0], 32'hFFFF_FFFC);
        chk("t6_pc_wrap", pop_log[1], 32'h0);

        mem_rdy = 1'b0;
        repeat (12) cycle();
        chk("drain_empty", exp_q.size(), 32'd0);
        chk("drain_out_valid", {31'b0, out_valid}, 32'h0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
